// File: rtl/dose_actuator_ctrl_pkg.sv
// dose_actuator_ctrl_pkg: shared FSM states, slot indices, default timing and slot arbitration
package dose_actuator_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_DETECT = 3'd2,
    S_CLOSE  = 3'd3,
    S_ALARM  = 3'd4
  } state_t;
  localparam logic [1:0] SLOT_MORNING   = 2'd0;
  localparam logic [1:0] SLOT_AFTERNOON = 2'd1;
  localparam logic [1:0] SLOT_EVENING   = 2'd2;
  localparam int DEF_PWM_PERIOD     = 1000000;
  localparam int DEF_PULSE_HOME     = 50000;
  localparam int DEF_PULSE_OPEN     = 100000;
  localparam int DEF_MOVE_CYCLES    = 25000000;
  localparam int DEF_DETECT_TIMEOUT = 100000000;
  localparam int DEF_MAX_RETRY      = 2;
  function automatic logic [1:0] pick_slot(input logic [2:0] req);
    return req[0] ? SLOT_MORNING : req[1] ? SLOT_AFTERNOON : SLOT_EVENING;
  endfunction
endpackage

// File: rtl/dose_actuator_ctrl_servo_pwm_gen.sv
// servo_pwm_gen: three servo PWM channels on one shared frame counter
//   CLOCK_50 clock, reset async active-low, width[2:0] requested high time per channel,
//   servo_pwm[2:0] channel outputs
module servo_pwm_gen
  import dose_actuator_ctrl_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int PULSE_HOME = DEF_PULSE_HOME,
  parameter int WW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [2:0][WW-1:0] width,
  output logic [2:0]         servo_pwm
);
  logic [WW-1:0]       cnt;
  logic [2:0][WW-1:0]  w;
  // widths are sampled only at frame start so a running frame never changes shape
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      cnt <= '0;
      w   <= {3{WW'(PULSE_HOME)}};
    end else begin
      cnt <= (cnt == WW'(PWM_PERIOD - 1)) ? '0 : cnt + WW'(1);
      if (cnt == '0) w <= width;
    end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign servo_pwm[i] = cnt < w[i];
  end
endmodule

// File: rtl/dose_actuator_ctrl.sv
// dose_actuator_ctrl: latches dose requests and drives one compartment servo at a time
//   CLOCK_50 clock, reset async active-low, morningP/afternoonP/eveningP one-cycle requests,
//   pill_detect raw drop sensor, ack_alarm active-low acknowledge; servo_pwm[2:0], pending[2:0],
//   busy, dispensed (1-cycle), alarm (latched), alarm_slot
module dose_actuator_ctrl
  import dose_actuator_ctrl_pkg::*;
#(
  parameter int PWM_PERIOD     = DEF_PWM_PERIOD,
  parameter int PULSE_HOME     = DEF_PULSE_HOME,
  parameter int PULSE_OPEN     = DEF_PULSE_OPEN,
  parameter int MOVE_CYCLES    = DEF_MOVE_CYCLES,
  parameter int DETECT_TIMEOUT = DEF_DETECT_TIMEOUT,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morningP,
  input  logic       afternoonP,
  input  logic       eveningP,
  input  logic       pill_detect,
  input  logic       ack_alarm,
  output logic [2:0] servo_pwm,
  output logic [2:0] pending,
  output logic       busy,
  output logic       dispensed,
  output logic       alarm,
  output logic [1:0] alarm_slot
);
  localparam int WW = $clog2(PWM_PERIOD + 1);
  localparam int CW = $clog2((DETECT_TIMEOUT > MOVE_CYCLES ? DETECT_TIMEOUT : MOVE_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_t             state;
  logic [1:0]         slot;
  logic [CW-1:0]      cnt;
  logic [RW-1:0]      retry;
  logic               done;
  logic [2:0]         sync;
  logic               pill_edge, serving, opening, start, move_done;
  logic [2:0]         act_mask, take_mask;
  logic [2:0][WW-1:0] width;
  // sync[1] is the synchronised sensor, sync[2] its previous value for edge detection
  assign pill_edge = sync[1] & ~sync[2];
  assign serving   = state inside {S_OPEN, S_DETECT, S_CLOSE};
  assign opening   = state inside {S_OPEN, S_DETECT};
  assign start     = state == S_IDLE && |pending && !alarm;
  assign move_done = cnt == CW'(MOVE_CYCLES - 1);
  assign act_mask  = serving ? 3'(1 << slot) : 3'b000;
  assign take_mask = start ? 3'(1 << pick_slot(pending)) : 3'b000;
  for (genvar i = 0; i < 3; i++) begin : g_w
    assign width[i] = (opening && slot == 2'(i)) ? WW'(PULSE_OPEN) : WW'(PULSE_HOME);
  end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      sync    <= '0;
      pending <= '0;
    end else begin
      sync    <= {sync[1:0], pill_detect};
      pending <= (pending | ({eveningP, afternoonP, morningP} & ~act_mask)) & ~take_mask;
    end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      state      <= S_IDLE;
      slot       <= '0;
      cnt        <= '0;
      retry      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      dispensed  <= 1'b0;
      alarm      <= 1'b0;
      alarm_slot <= '0;
    end else begin
      dispensed <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_OPEN;
            slot  <= pick_slot(pending);
            cnt   <= '0;
            retry <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        S_OPEN:
          if (pill_edge) begin
            state <= S_CLOSE;
            cnt   <= '0;
            done  <= 1'b1;
          end else if (move_done) begin
            state <= S_DETECT;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        S_DETECT:
          if (pill_edge || cnt == CW'(DETECT_TIMEOUT - 1)) begin
            state <= S_CLOSE;
            cnt   <= '0;
            done  <= pill_edge;
          end else cnt <= cnt + CW'(1);
        S_CLOSE:
          if (!move_done) cnt <= cnt + CW'(1);
          else if (done) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            dispensed <= 1'b1;
          end else if (retry < RW'(MAX_RETRY)) begin
            state <= S_OPEN;
            cnt   <= '0;
            retry <= retry + RW'(1);
          end else begin
            state      <= S_ALARM;
            alarm      <= 1'b1;
            alarm_slot <= slot;
          end
        S_ALARM:
          if (!ack_alarm) begin
            state <= S_IDLE;
            alarm <= 1'b0;
            busy  <= 1'b0;
          end
        default: state <= S_IDLE;
      endcase
    end
  servo_pwm_gen #(.PWM_PERIOD(PWM_PERIOD), .PULSE_HOME(PULSE_HOME), .WW(WW)) u_pwm (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .width    (width),
    .servo_pwm(servo_pwm)
  );
endmodule
